serial_subtractor_five_bits: RTL and testbench



---
 rtl/serial_subtractor_five_bits_pkg.sv | 13 +
 rtl/serial_subtractor_five_bits_fsub.sv | 13 +
 rtl/serial_subtractor_five_bits.sv | 105 ++++++++++
 tb/tb_serial_subtractor_five_bits.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_five_bits_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// default operand width.
package serial_subtractor_five_bits_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

endpackage

// File: rtl/serial_subtractor_five_bits_fsub.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out of this bit.
module full_subtractor_one_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_five_bits.sv
// Bit-serial subtractor computing diff = A - B - borrowIn, LSB first, one bit
// per clock, with a start/busy/done handshake and results held until the next completion.
module serial_subtractor_five_bits
    import serial_subtractor_five_bits_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrowIn,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    stateT            state;
    stateT            nextState;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] resSr;
    logic [WIDTH-1:0] resNext;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             aMsb;
    logic             bMsb;
    logic             bitD;
    logic             bitBout;
    logic             accept;
    logic             lastBit;

    full_subtractor_one_bit uBit (
        .a    (opA[0]),
        .b    (opB[0]),
        .bin  (br),
        .d    (bitD),
        .bout (bitBout)
    );

    assign accept  = (state != BUSY) && start;
    assign lastBit = (state == BUSY) && (cnt == CNT_W'(WIDTH - 1));
    assign resNext = {bitD, resSr[WIDTH-1:1]};
    assign busy    = (state == BUSY);
    assign done    = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = BUSY;
            BUSY:    if (lastBit) nextState = DONE;
            DONE:    nextState = start ? BUSY : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operand shifting, borrow chain and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opA       <= '0;
            opB       <= '0;
            resSr     <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            aMsb      <= 1'b0;
            bMsb      <= 1'b0;
            diff      <= '0;
            borrowOut <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            opA  <= A;
            opB  <= B;
            br   <= borrowIn;
            cnt  <= '0;
            aMsb <= A[WIDTH-1];
            bMsb <= B[WIDTH-1];
        end else if (state == BUSY) begin
            opA   <= opA >> 1;
            opB   <= opB >> 1;
            br    <= bitBout;
            resSr <= resNext;
            cnt   <= cnt + CNT_W'(1);
            if (lastBit) begin
                diff      <= resNext;
                borrowOut <= bitBout;
                // The shifted operands no longer hold their MSBs, hence the saved copies
                overflow  <= (aMsb != bMsb) && (bitD != aMsb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_five_bits.sv
// Scoreboard bench for the bit-serial subtractor: directed operations push their
// hand-computed results; a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor_five_bits;

    localparam int W = 5;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           doneAt;
    } expT;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         borrowIn = 1'b0;
    logic [W-1:0] diff;
    logic         borrowOut;
    logic         overflow;
    logic         busy;
    logic         done;

    int  compared = 0;
    int  mismatched = 0;
    int  edgeCnt = 0;
    expT sbq[$];
    expT held = '{'0, 1'b0, 1'b0, 0};

    serial_subtractor_five_bits #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .borrowIn  (borrowIn),
        .diff      (diff),
        .borrowOut (borrowOut),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: results on done, held values otherwise, zeros under reset
    always @(negedge clk) begin
        expT e;
        if (rst) begin
            check("rstDiff", 32'(diff), 32'd0);
            check("rstBusyDone", {30'd0, busy, done}, 32'd0);
            check("rstFlags", {30'd0, borrowOut, overflow}, 32'd0);
            held = '{'0, 1'b0, 1'b0, 0};
        end else if (done) begin
            check("busyWithDone", 32'(busy), 32'd0);
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpectedDone: got done=1, expected no pending result (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("borrowOut", 32'(borrowOut), 32'(e.bo));
                check("overflow", 32'(overflow), 32'(e.ov));
                check("doneLatency", edgeCnt, e.doneAt);
                held = e;
            end
        end else begin
            check("holdDiff", 32'(diff), 32'(held.d));
            check("holdFlags", {30'd0, borrowOut, overflow}, {30'd0, held.bo, held.ov});
        end
    end

    // Entered at a negedge; waits out any running operation, then issues start for one edge
    task automatic doOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic ebo, input logic eov, input bit push);
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        A = a;
        B = b;
        borrowIn = bin;
        start = 1'b1;
        if (push) sbq.push_back('{ed, ebo, eov, edgeCnt + 1 + W});
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idleBusy", 32'(busy), 32'd0);
            check("idleDone", 32'(done), 32'd0);
        end

        doOp(5'b11001, 5'b00111, 1'b0, 5'b10010, 1'b0, 1'b0, 1'b1);
        doOp(5'b00000, 5'b00001, 1'b1, 5'b11110, 1'b1, 1'b0, 1'b1);
        doOp(5'b00001, 5'b11111, 1'b0, 5'b00010, 1'b1, 1'b0, 1'b1);
        doOp(5'b10000, 5'b00011, 1'b1, 5'b01100, 1'b0, 1'b1, 1'b1);
        doOp(5'b01111, 5'b10000, 1'b0, 5'b11111, 1'b1, 1'b1, 1'b1);
        doOp(5'b10000, 5'b00001, 1'b0, 5'b01111, 1'b0, 1'b1, 1'b1);

        // Start held high across BUSY with scrambled inputs, then a back-to-back accept
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        A = 5'b01100;
        B = 5'b10000;
        borrowIn = 1'b0;
        start = 1'b1;
        sbq.push_back('{5'b11100, 1'b1, 1'b1, edgeCnt + 1 + W});
        @(negedge clk);
        for (int n = 0; n < 20 && busy; n++) begin
            A = A + 5'd7;
            B = B ^ 5'b10110;
            borrowIn = ~borrowIn;
            @(negedge clk);
        end
        A = 5'b00101;
        B = 5'b00011;
        borrowIn = 1'b0;
        sbq.push_back('{5'b00010, 1'b0, 1'b0, edgeCnt + 1 + W});
        @(negedge clk);
        start = 1'b0;

        // Asynchronous reset in the third BUSY cycle aborts the operation
        doOp(5'b10101, 5'b01010, 1'b0, 5'b01011, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("asyncRstDiff", 32'(diff), 32'd0);
        check("asyncRstBusy", 32'(busy), 32'd0);
        check("asyncRstDone", 32'(done), 32'd0);
        check("asyncRstFlags", {30'd0, borrowOut, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        doOp(5'b11111, 5'b11111, 1'b1, 5'b11111, 1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 50 && sbq.size() != 0; n++) @(negedge clk);
        if (sbq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d results still pending, expected 0", sbq.size());
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no end of test, expected completion before 50000");
        $fatal(1, "watchdog expired");
    end

endmodule
